// File: rtl/ov7670_pixel_packer_pkg.sv
// Shared definitions for the OV7670 pixel packer: frame geometry defaults,
// FSM state encoding and the RGB565 -> RGB444 conversion.
package ov7670_pkg;

  localparam int H_PIX_DEF   = 640;
  localparam int V_LINES_DEF = 480;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = IDLE,
    S_ACTIVE = ACTIVE,
    S_DONE   = DONE
  } state_t;

  // Truncating conversion: keep the top 4 bits of each colour field.
  function automatic logic [11:0] rgb565_to_444(input logic [15:0] p);
    return {p[15:12], p[10:7], p[4:1]};
  endfunction

endpackage

// File: rtl/ov7670_pixel_packer_if.sv
// Frame-buffer write port bundle between the pixel packer (master) and the BRAM write side (slave).
// Handshake: fb_we is valid, fb_ready is ready; a write transfers on a cycle where both are high,
// and fb_addr/fb_data stay stable while fb_we is high and fb_ready is low.
interface ov7670_pixel_packer_if #(
  parameter int ADDR_W = 19
);
  logic              fb_we;
  logic              fb_ready;
  logic [ADDR_W-1:0] fb_addr;
  logic [11:0]       fb_data;

  modport master (output fb_we, output fb_addr, output fb_data, input fb_ready);
  modport slave  (input fb_we, input fb_addr, input fb_data, output fb_ready);
endinterface

// File: rtl/ov7670_pixel_packer_pixel_fifo.sv
// Synchronous pixel FIFO. Head is shown combinationally; when empty the output
// holds the last popped word. A push into a full FIFO is accepted only if a pop happens too.
module pixel_fifo #(
  parameter int W     = 31,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] hold_q;
  logic         do_pop;
  logic         do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? hold_q : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      hold_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        hold_q <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/ov7670_pixel_packer.sv
// Pairs camera bytes into RGB565 pixels, converts to RGB444, generates frame-buffer
// addresses and queues writes. Optional 2x downscale under macro PACKER_DECIMATE_EN.
module ov7670_pixel_packer
  import ov7670_pkg::*;
#(
  parameter int H_PIX      = H_PIX_DEF,
  parameter int V_LINES    = V_LINES_DEF,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  wclk,
  input  logic                  reset,
  input  logic [7:0]            byte_in,
  input  logic                  byte_we,
  input  logic                  frame_start,
  input  logic                  line_start,
  ov7670_pixel_packer_if.master fb,
  output logic                  frame_done,
  output logic                  overflow,
  output logic [1:0]            dbg_state
);
  localparam int XW = $clog2(H_PIX + 1);
  localparam int YW = $clog2(V_LINES + 1);
  localparam int DW = ADDR_W + 12;
`ifdef PACKER_DECIMATE_EN
  localparam int ROW_STEP = H_PIX / 2;
`else
  localparam int ROW_STEP = H_PIX;
`endif

  state_t            state_q, state_d;
  logic [XW-1:0]     x_q, x_e;
  logic [YW-1:0]     y_q, y_e;
  logic [ADDR_W-1:0] row_q, row_e;
  logic              phase_q, phase_e;
  logic              first_q, first_e;
  logic [7:0]        hi_q;

  logic              accept, formed, keep, push, pop, last_pix;
  logic              full, empty;
  logic [ADDR_W-1:0] pix_addr;
  logic [DW-1:0]     fifo_din, fifo_dout;

  // Counter values after this cycle's frame/line clears, so a byte arriving
  // together with a start pulse is treated as phase 0 of the new line.
  always_comb begin
    x_e     = x_q;
    y_e     = y_q;
    row_e   = row_q;
    phase_e = phase_q;
    first_e = first_q;
    if (frame_start) begin
      x_e     = '0;
      y_e     = '0;
      row_e   = '0;
      phase_e = 1'b0;
      first_e = 1'b1;
    end
    if (line_start) begin
      x_e     = '0;
      phase_e = 1'b0;
      if (first_e) begin
        first_e = 1'b0;
      end else if (int'(y_e) < V_LINES) begin
        y_e = y_e + 1'b1;
`ifdef PACKER_DECIMATE_EN
        if (!y_e[0] && int'(y_e) < V_LINES) row_e = row_e + ADDR_W'(ROW_STEP);
`else
        if (int'(y_e) < V_LINES) row_e = row_e + ADDR_W'(ROW_STEP);
`endif
      end
    end
  end

  assign accept   = byte_we && (state_q == S_ACTIVE || frame_start);
  assign formed   = accept && phase_e;
  assign last_pix = formed && (x_e == XW'(H_PIX - 1)) && (y_e == YW'(V_LINES - 1));

`ifdef PACKER_DECIMATE_EN
  assign keep     = (int'(x_e) < H_PIX) && (int'(y_e) < V_LINES) && !x_e[0] && !y_e[0];
  assign pix_addr = row_e + ADDR_W'(x_e >> 1);
`else
  assign keep     = (int'(x_e) < H_PIX) && (int'(y_e) < V_LINES);
  assign pix_addr = row_e + ADDR_W'(x_e);
`endif

  assign push     = formed && keep;
  assign pop      = fb.fb_we && fb.fb_ready;
  assign fifo_din = {pix_addr, rgb565_to_444({hi_q, byte_in})};

  pixel_fifo #(
    .W     (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wclk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  assign fb.fb_we   = !empty;
  assign fb.fb_addr = fifo_dout[DW-1:12];
  assign fb.fb_data = fifo_dout[11:0];
  assign dbg_state  = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (frame_start) state_d = S_ACTIVE;
      S_ACTIVE: if (frame_start) state_d = S_ACTIVE;
                else if (last_pix) state_d = S_DONE;
      S_DONE:   if (frame_start) state_d = S_ACTIVE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge wclk) begin
    if (reset) begin
      x_q        <= '0;
      y_q        <= '0;
      row_q      <= '0;
      phase_q    <= 1'b0;
      first_q    <= 1'b0;
      hi_q       <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      x_q        <= x_e;
      y_q        <= y_e;
      row_q      <= row_e;
      phase_q    <= phase_e;
      first_q    <= first_e;
      frame_done <= last_pix;
      if (accept) begin
        phase_q <= !phase_e;
        if (!phase_e) hi_q <= byte_in;
      end
      // x saturates at H_PIX so out-of-line pixels never wrap into the row.
      if (formed && int'(x_e) < H_PIX) x_q <= x_e + 1'b1;
      if (frame_start)                 overflow <= 1'b0;
      else if (push && full && !pop)   overflow <= 1'b1;
    end
  end

endmodule
